hex_word_assembler: RTL
=======================

# hex_word_assembler

Assembles an 8-bit byte stream (network receive path, debug UART, or any byte-wide producer) into 32-bit words and holds the most recent complete word as the 8-digit value for the seven-segment hex display driver. It sits directly upstream of the display driver, and its `data_out` connects straight to the driver's 32-bit data input. It also provides a one-cycle update strobe, a saturating word counter, a freeze control, and an optional stale-partial-word timeout.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles after which a partial word is discarded. Used only with `HEX_TIMEOUT_EN`. Legal values are ≥ 2.
- `clk_in`  input  1  system clock, the single clock domain.
- `rst_in`  input  1  reset, synchronous and active-high.
- `byte_in`  input  8  incoming byte.
- `byte_valid_in`  input  1  `byte_in` is accepted on every cycle this is high; there is no backpressure.
- `byte_last_in`  input  1  marks the accepted byte as the final byte of a word; sampled only when `byte_valid_in` is high.
- `freeze_in`  input  1  when high, completed words do not update `data_out`.
- `data_out`  output  32  last committed word, first byte in [31:24].
- `word_valid_out`  output  1  one-cycle pulse on the cycle `data_out` changes.
- `word_count_out`  output  16  completed words, saturating.
- `timeout_out`  output  1  one-cycle pulse when a partial word is discarded by timeout.

## Operation
- The FSM states are `IDLE` (byte index 0) and `FILL` (byte index 1–3).
- On an accepted byte at index i, the byte is written to shift-register lane [31-8i:24-8i] and the index advances.
- **Word completion** occurs on an accepted byte at index 3, or on an accepted byte with `byte_last_in`=1 at any index.
  - Lanes not yet written are zero; the word is left-justified.
  - The index returns to 0, the shift register clears, and the FSM goes to `IDLE`.
- **Commit.** On completion with `freeze_in`=0, the word is copied to `data_out` and `word_valid_out` pulses.
- **Freeze.** On completion with `freeze_in`=1, the word is dropped: `data_out` holds and there is no pulse.
- **Counting.** `word_count_out` increments on every completion, frozen or not, and saturates at 16'hFFFF.
- **Ignored input.** `byte_last_in` with `byte_valid_in`=0 has no effect.
- **Frozen boundary.** `freeze_in` is sampled in the completion cycle only. Deasserting it does not replay a dropped word.
- **Back-to-back words.** A byte accepted in the cycle after a completion starts a new word at index 0. Back-to-back words at full rate are supported.
- **Reset.** `rst_in` discards any partial word and zeroes the index and shift register, regardless of the current state. The block does not depend on the state of its inputs during reset.

## Timing
- Reset values:
  - `data_out` = 32'h0000_0000
  - `word_valid_out` = 0
  - `word_count_out` = 0
  - `timeout_out` = 0
  - FSM in `IDLE`
- Latency: a completing byte accepted at rising edge N updates `data_out`, `word_valid_out` and `word_count_out` so they are visible after edge N. All outputs are registered.
- Throughput: one byte per cycle sustained, one word per 4 cycles, with no dead cycles.
- The timeout counter resets on every accepted byte. It counts only while the FSM is in `FILL`.
- In `FILL`, after `TIMEOUT_CYCLES` consecutive cycles without `byte_valid_in`:
  - the partial word is discarded;
  - `timeout_out` pulses for one cycle;
  - the FSM returns to `IDLE`;
  - `word_count_out` and `data_out` are unchanged.
- If a byte is accepted in the same cycle the timeout would expire, the byte wins and no timeout occurs.

## Configuration
- `HEX_TIMEOUT_EN` defined: the timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) and the discard logic are compiled in.
- `HEX_TIMEOUT_EN` undefined:
  - no counter is built;
  - a partial word persists indefinitely until it is completed or reset;
  - `timeout_out` is tied to 0;
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- The shared package `hex_pkg` holds:
  - `WORD_BYTES` = 4
  - `typedef logic [1:0] byte_idx_t`
  - `typedef enum logic {IDLE, FILL} asm_state_t`
  - `WORD_COUNT_W` = 16
- There is no sub-module. The timeout counter is small enough to live inline under the macro guard.

## Test plan
- **Full word.** Reset, then bytes DE, AD, BE, EF on 4 consecutive cycles → `data_out`=32'hDEADBEEF one cycle after EF; `word_valid_out` high for exactly 1 cycle; `word_count_out`=1.
- **Short word.** Bytes 12, 34 with `byte_last_in` on 34 → `data_out`=32'h12340000, one pulse; then the next byte 56 lands in [31:24].
- **Freeze.** `freeze_in`=1, bytes 01 02 03 04 → `data_out` unchanged from prior 32'h12340000; no pulse; `word_count_out` increments.
- **Reset mid-word.** Reset asserted after 2 bytes of a word → all outputs 0. The next 4 bytes AA BB CC DD give 32'hAABBCCDD, proving the partial word was discarded.
- **Timeout (with `HEX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10).** 1 byte, then 10 idle cycles → `timeout_out` pulses once. A byte arriving on cycle 10 instead → no pulse. Without the macro → no pulse ever.
- **Saturation.** Force 65 537 completions → `word_count_out` holds 16'hFFFF.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and constants for the hex word assembler.
package hex_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int WORD_COUNT_W = 16;

  typedef logic [1:0] byte_idx_t;

  typedef enum logic {IDLE, FILL} asm_state_t;

  // Place a byte into its lane of a left-justified word; lane 0 is [31:24].
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input byte_idx_t   idx,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      default: res[7:0]   = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hex_word_assembler.sv
// Packs a byte stream into 32-bit words for the hex display driver.
// Optional stale-partial-word timeout is built only when HEX_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no partial word held, next byte lands in [31:24]
// FILL  | 1-3 bytes of the current word held in the shift register
module hex_word_assembler
  import hex_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid_in,
  input  logic                    byte_last_in,
  input  logic                    freeze_in,
  output logic [31:0]             data_out,
  output logic                    word_valid_out,
  output logic [WORD_COUNT_W-1:0] word_count_out,
  output logic                    timeout_out
);

  localparam byte_idx_t LAST_IDX = byte_idx_t'(WORD_BYTES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("hex_word_assembler: TIMEOUT_CYCLES must be at least 2");
  end

  asm_state_t  state, state_next;
  byte_idx_t   idx, idx_next;
  logic [31:0] shreg, shreg_next;
  logic [31:0] assembled;
  logic        complete;
  logic        commit;
  logic        expire;

`ifdef HEX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr;

  // Down-counter reloaded by every accepted byte; it reaches zero on the
  // last idle cycle before expiry, so a byte in that cycle still wins.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmr         <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= expire;
      if (byte_valid_in) begin
        tmr <= TMR_LOAD;
      end else if (state == FILL && tmr != '0) begin
        tmr <= tmr - 1'b1;
      end
    end
  end

  assign expire = (state == FILL) && !byte_valid_in && (tmr == '0);
`else
  assign expire      = 1'b0;
  assign timeout_out = 1'b0;
`endif

  assign assembled = lane_insert(shreg, idx, byte_in);
  assign complete  = byte_valid_in && (byte_last_in || idx == LAST_IDX);
  assign commit    = complete && !freeze_in;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    if (byte_valid_in) begin
      if (complete) begin
        state_next = IDLE;
        idx_next   = '0;
        shreg_next = '0;
      end else begin
        state_next = FILL;
        idx_next   = idx + 1'b1;
        shreg_next = assembled;
      end
    end else if (expire) begin
      state_next = IDLE;
      idx_next   = '0;
      shreg_next = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      idx            <= '0;
      shreg          <= '0;
      data_out       <= '0;
      word_valid_out <= 1'b0;
      word_count_out <= '0;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      shreg          <= shreg_next;
      word_valid_out <= commit;
      if (commit) begin
        data_out <= assembled;
      end
      // Frozen completions still count; the counter sticks at all-ones.
      if (complete && word_count_out != '1) begin
        word_count_out <= word_count_out + 1'b1;
      end
    end
  end

endmodule
